// File: rtl/wb_mem_arbiter.sv
// Two-master pipelined Wishbone arbiter (m0 load/store, m1 fetch) in front of one slave.
// Define ARB_ROUND_ROBIN_EN to alternate grants in IDLE when both masters request.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_m0_stb,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_data,
  input  logic [2:0]    i_m0_sel,
  output logic [DW-1:0] o_m0_data,
  output logic          o_m0_ack,
  output logic          o_m0_stall,
  input  logic          i_m1_stb,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_data,
  input  logic [2:0]    i_m1_sel,
  output logic [DW-1:0] o_m1_data,
  output logic          o_m1_ack,
  output logic          o_m1_stall,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_data,
  output logic [2:0]    o_s_sel,
  input  logic [DW-1:0] i_s_data,
  input  logic          i_s_ack,
  input  logic          i_s_stall,
  output logic          o_err
);

  // state | meaning
  // IDLE  | no grant; both masters stalled, arbitration happens here
  // G0    | m0 owns the slave until it drops stb with nothing outstanding
  // G1    | m1 owns the slave until it drops stb with nothing outstanding
  typedef enum logic [1:0] {S_IDLE, S_G0, S_G1} state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_OUT);

  state_t     r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic       r_err;
  logic       w_g0, w_g1, w_full, w_accept, w_ack_ok;
`ifdef ARB_ROUND_ROBIN_EN
  logic       r_last, w_last_next;  // 0 = m0 last released, 1 = m1
`endif

  assign w_g0   = (r_state == S_G0);
  assign w_g1   = (r_state == S_G1);
  assign w_full = (r_cnt == LP_MAX);

  assign o_s_stb  = ((w_g0 & i_m0_stb) | (w_g1 & i_m1_stb)) & ~w_full;
  assign o_s_we   = w_g1 ? i_m1_we   : i_m0_we;
  assign o_s_addr = w_g1 ? i_m1_addr : i_m0_addr;
  assign o_s_data = w_g1 ? i_m1_data : i_m0_data;
  assign o_s_sel  = w_g1 ? i_m1_sel  : i_m0_sel;

  assign o_m0_stall = ~w_g0 | i_s_stall | w_full;
  assign o_m1_stall = ~w_g1 | i_s_stall | w_full;

  // Acks with nothing outstanding are swallowed and flagged instead of routed
  assign w_accept = o_s_stb & ~i_s_stall;
  assign w_ack_ok = i_s_ack & (r_cnt != 4'd0) & (w_g0 | w_g1);
  assign o_m0_ack = w_ack_ok & w_g0;
  assign o_m1_ack = w_ack_ok & w_g1;
  assign o_m0_data = i_s_data;
  assign o_m1_data = i_s_data;
  assign o_err     = r_err;

  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_accept, w_ack_ok})
      2'b10:   w_cnt_next = r_cnt + 4'd1;
      2'b01:   w_cnt_next = r_cnt - 4'd1;
      default: w_cnt_next = r_cnt;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
`ifdef ARB_ROUND_ROBIN_EN
    w_last_next = r_last;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (i_m0_stb && i_m1_stb) w_state_next = r_last ? S_G0 : S_G1;
        else
`endif
        if (i_m0_stb)      w_state_next = S_G0;
        else if (i_m1_stb) w_state_next = S_G1;
      end
      S_G0: begin
        if (!i_m0_stb && (w_cnt_next == 4'd0)) begin
          w_state_next = i_m1_stb ? S_G1 : S_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          w_last_next = 1'b0;
`endif
        end
      end
      S_G1: begin
        if (!i_m1_stb && (w_cnt_next == 4'd0)) begin
          w_state_next = i_m0_stb ? S_G0 : S_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          w_last_next = 1'b1;
`endif
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= r_err | (i_s_ack & ~w_ack_ok);
`ifdef ARB_ROUND_ROBIN_EN
      r_last  <= w_last_next;
`endif
    end
  end

endmodule
